// File: rtl/test_harness_ctrl_pkg.sv
// Shared harness definitions: FSM state encodings and cycle-count width.
package test_harness_ctrl_pkg;

  localparam int CYC_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/test_harness_ctrl_counter.sv
// Loadable down-counter with zero flag; stops at zero, load has priority over decrement.
module harness_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/test_harness_ctrl.sv
// Test-harness sequencer: holds the DUT in reset, times the run, and latches pass/timeout on completion.
module test_harness_ctrl
  import test_harness_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_fail,
  input  logic             dut_finish,
  output logic             dut_reset,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  // Counter is loaded with N-1 so RESET spans exactly RESET_CYCLES posedges.
  localparam logic [CYC_W-1:0] RST_LOAD = CYC_W'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] TO_LIMIT = CYC_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             fail_q, fail_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CYC_W-1:0] cycles_inc;

  assign cycles_inc = cycles_q + 1'b1;

  harness_counter #(.W(CYC_W)) u_rst_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (RST_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          cycles_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          fail_d    = 1'b0;
          cnt_load  = 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt_zero) begin
          state_d = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        cycles_d = cycles_inc;
        fail_d   = fail_q | dut_fail;
        // Finish wins over a coincident timeout.
        if (dut_finish) begin
          state_d   = ST_DONE;
          pass_d    = ~(fail_q | dut_fail);
          timeout_d = 1'b0;
        end else if (cycles_inc == TO_LIMIT) begin
          state_d   = ST_DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cycles_q  <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      fail_q    <= fail_d;
    end
  end

  assign dut_reset = (state_q != ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done & pass_q;
  assign timeout   = done & timeout_q;
  assign cycles    = cycles_q;

endmodule

// File: doc/test_harness_ctrl.md
TEST_HARNESS_CTRL -- requirements
Module: test_harness_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 4: number of cycles the DUT reset is held after start (legal range >= 1).
REQ-002 SHALL have parameter TIMEOUT, default 1000: maximum number of RUN cycles before the test is declared hung (legal range >= 1, < 2^32).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high harness reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a test run.
REQ-006 SHALL have port dut_fail  input  1  fail flag driven by a test module.
REQ-007 SHALL have port dut_finish  input  1  finish flag driven by a test module.
REQ-008 SHALL have port dut_reset  output  1  active-high reset driven to the test module.
REQ-009 SHALL have port done  output  1  high when a run has completed and the results are valid.
REQ-010 SHALL have port pass  output  1  valid when done is high: finish was seen with no fail and no timeout.
REQ-011 SHALL have port timeout  output  1  valid when done is high: the run hit TIMEOUT.
REQ-012 SHALL have port cycles  output  32  number of posedges spent in RUN during the last or current run.

Function
REQ-013 SHALL implement a four-state FSM with states IDLE, RESET, RUN and DONE.
REQ-014 IDLE: start=1 SHALL transition to RESET, clear cycles/pass/timeout/fail latch, and load the reset counter.
REQ-015 RESET: dut_reset SHALL be held at 1 for exactly RESET_CYCLES posedges, then the FSM SHALL transition to RUN.
REQ-016 dut_reset SHALL be 1 in IDLE, RESET and DONE, and 0 only in RUN.
REQ-017 RUN: every posedge SHALL increment cycles by 1.
REQ-018 RUN: dut_fail=1 at any posedge SHALL set a sticky fail latch; the run SHALL continue.
REQ-019 RUN: dut_finish=1 SHALL transition to DONE with pass = NOT(fail latch OR dut_fail this cycle) and timeout=0.
REQ-020 RUN: when dut_finish=0 and the incremented cycles equals TIMEOUT, the FSM SHALL transition to DONE with timeout=1 and pass=0.
REQ-021 If dut_finish and the TIMEOUT condition occur in the same cycle, finish SHALL take priority (timeout=0).
REQ-022 dut_fail and dut_finish SHALL be ignored outside RUN.
REQ-023 start SHALL be ignored in RESET and RUN.
REQ-024 DONE: done=1; pass, timeout and cycles SHALL hold stable; start=1 SHALL begin a new run exactly as from IDLE (done drops on that edge).
REQ-025 done, pass and timeout SHALL be 0 in all states other than DONE.

Reset
REQ-026 reset=1 SHALL, asynchronously and regardless of state, force state=IDLE, dut_reset=1, done=0, pass=0, timeout=0, cycles=0, fail latch=0, reset counter=0.
REQ-027 On reset deassertion the block SHALL remain in IDLE until start.

Structure
REQ-028 FSM state encodings (2-bit IDLE=0, RESET=1, RUN=2, DONE=3) SHALL live in the shared harness package/include, alongside the 32-bit cycle-count width constant.
REQ-029 A single sub-module, harness_counter (loadable down-counter with zero flag), SHALL implement the RESET_CYCLES countdown; the cycle count stays in the top level.

Verification (RESET_CYCLES=4, TIMEOUT=16)
REQ-030 Pulse start in IDLE, dut_finish=1 on the 3rd RUN posedge, dut_fail=0 -> dut_reset high for 4 cycles, then done=1, pass=1, timeout=0, cycles=3.
REQ-031 dut_fail=1 on RUN cycle 1 only, dut_finish on cycle 2 -> done=1, pass=0, timeout=0, cycles=2.
REQ-032 Never assert dut_finish -> done=1, timeout=1, pass=0, cycles=16 after exactly 16 RUN cycles; dut_finish on cycle 16 -> pass=1, timeout=0.
REQ-033 dut_fail=1 and dut_finish=1 on the same edge -> done=1, pass=0; start pulses during RESET/RUN -> no effect.
REQ-034 Assert reset asynchronously mid-RUN -> dut_reset=1, done=0, cycles=0 immediately without a clock edge; FSM stays in IDLE after release.
REQ-035 From DONE(pass=1), pulse start -> done=0 and cycles=0 on that edge; a second run with a fail completes with pass=0.
